// File: rtl/uart_transmit.sv
// uart_transmit: 8N1 LSB-first UART transmitter with a one-byte holding register,
// sticky overrun flag and a level drain interrupt.
module uart_transmit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] clk_div,
  input  logic [7:0]  tx_data,
  input  logic        write,
  input  logic        irq_en,
  input  logic        clr_ovr,
  output logic        tx,
  output logic        full,
  output logic        busy,
  output logic        overrun,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      state_q, state_d;
  logic [7:0]  hold_q, hold_d, shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic [31:0] cnt_q, cnt_d, per_q, per_d;
  logic        full_q, full_d, tx_q, tx_d, ovr_q, ovr_d, irq_q, irq_d;
  logic        accept, done, load, drained;
  assign accept  = write & ~full_q;
  assign done    = cnt_q == per_q - 32'd1;
  assign load    = full_q & (state_q == IDLE | (state_q == STOP & done));
  assign drained = state_q == STOP & done & ~full_q;
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    per_d   = per_q;
    tx_d    = tx_q;
    cnt_d   = (state_q == IDLE | done) ? 32'd0 : cnt_q + 32'd1;
    hold_d  = accept ? tx_data : hold_q;
    full_d  = accept | (full_q & ~load);
    ovr_d   = (write & full_q) | (ovr_q & ~clr_ovr);
    irq_d   = irq_en & ~accept & (irq_q | drained);
    case (state_q)
      IDLE: tx_d = 1'b1;
      START: if (done) begin
        state_d = DATA;
        bit_d   = 3'd0;
        tx_d    = shift_q[0];
      end
      DATA: if (done) begin
        bit_d   = bit_q + 3'd1;
        shift_d = shift_q >> 1;
        tx_d    = bit_q == 3'd7 ? 1'b1 : shift_q[1];
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (done) begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        shift_d = '0;
        hold_d  = '0;
        bit_d   = '0;
        cnt_d   = '0;
        per_d   = 32'd1;
        full_d  = 1'b0;
        ovr_d   = 1'b0;
        irq_d   = 1'b0;
      end
    endcase
    // loading from IDLE or at stop completion starts the next frame with no gap
    if (load) begin
      state_d = START;
      shift_d = hold_q;
      per_d   = clk_div == 32'd0 ? 32'd1 : clk_div;
      cnt_d   = 32'd0;
      tx_d    = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      hold_q  <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      per_q   <= 32'd1;
      full_q  <= 1'b0;
      tx_q    <= 1'b1;
      ovr_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      full_q  <= full_d;
      tx_q    <= tx_d;
      ovr_q   <= ovr_d;
      irq_q   <= irq_d;
    end
  end
  assign tx      = tx_q;
  assign full    = full_q;
  assign busy    = (state_q != IDLE) | full_q;
  assign overrun = ovr_q;
  assign irq     = irq_q;
endmodule

// File: tb/tb_uart_transmit.sv
// tb_uart_transmit: directed checks of framing, queuing, overrun, divider, reset and irq.
module tb_uart_transmit;
  logic        clk = 1'b0, rst = 1'b0;
  logic [31:0] clk_div = 32'd4;
  logic [7:0]  tx_data = 8'd0;
  logic        write = 1'b0, irq_en = 1'b0, clr_ovr = 1'b0;
  logic        tx, full, busy, overrun, irq;
  int          n_vec = 0, n_bad = 0;
  logic [9:0]  f;
  logic [19:0] s;
  uart_transmit dut (
    .clk(clk), .rst(rst), .clk_div(clk_div), .tx_data(tx_data), .write(write),
    .irq_en(irq_en), .clr_ovr(clr_ovr), .tx(tx), .full(full), .busy(busy),
    .overrun(overrun), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send_write(input logic [7:0] d);
    @(negedge clk);
    write = 1'b1;
    tx_data = d;
    @(negedge clk);
    write = 1'b0;
  endtask
  task automatic chk_frame(input logic [7:0] d, input int per, input logic exp_irq);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < per; j++) begin
        @(negedge clk);
        chk("frame_bit", tx, fr[i]);
      end
    @(negedge clk);
    chk("frame_busy", busy, 0);
    chk("frame_irq", irq, exp_irq);
    chk("frame_idle_tx", tx, 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_irq", irq, 0);
    rst = 1'b1;
    irq_en = 1'b1;
    clk_div = 32'd4;
    send_write(8'hA5);
    chk("load_full", full, 1);
    chk("load_busy", busy, 1);
    chk("load_tx_still_high", tx, 1);
    chk_frame(8'hA5, 4, 1);
    clk_div = 32'd3;
    send_write(8'h00);
    chk("irq_clr_by_write", irq, 0);
    s = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      write = (c == 0);
      tx_data = 8'hFF;
      chk("b2b_bit", tx, s[c / 3]);
      if (c == 1) chk("b2b_full_q", full, 1);
      if (c == 29) chk("b2b_full_pre", full, 1);
      if (c == 30) chk("b2b_full_post", full, 0);
    end
    @(negedge clk);
    chk("b2b_busy", busy, 0);
    clk_div = 32'd2;
    send_write(8'h3C);
    s = {1'b1, 8'h5A, 1'b0, 1'b1, 8'h3C, 1'b0};
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      write = (c < 2);
      tx_data = c == 0 ? 8'h5A : 8'h12;
      chk("ovr_bit", tx, s[c / 2]);
      if (c == 1) chk("ovr_full", full, 1);
      if (c == 2) chk("ovr_set", overrun, 1);
    end
    @(negedge clk);
    chk("ovr_busy", busy, 0);
    chk("ovr_sticky", overrun, 1);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    chk("ovr_clr", overrun, 0);
    clk_div = 32'd0;
    send_write(8'hC3);
    chk_frame(8'hC3, 1, 1);
    clk_div = 32'd1;
    send_write(8'h3C);
    chk_frame(8'h3C, 1, 1);
    clk_div = 32'd8;
    send_write(8'h81);
    f = {1'b1, 8'h7E, 1'b0};
    s = {10'd0, 1'b1, 8'h81, 1'b0};
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      write = (c == 0);
      tx_data = 8'h7E;
      if (c == 10) clk_div = 32'd2;
      chk("div_bit", tx, c < 80 ? s[c / 8] : f[(c - 80) / 2]);
    end
    @(negedge clk);
    chk("div_busy", busy, 0);
    clk_div = 32'd4;
    send_write(8'h55);
    f = {1'b1, 8'h55, 1'b0};
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      write = (c == 0);
      tx_data = 8'hAA;
      chk("rst_mid_bit", tx, f[c / 4]);
      if (c == 1) chk("rst_mid_full", full, 1);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rst_mid_tx", tx, 1);
    chk("rst_mid_full0", full, 0);
    chk("rst_mid_irq", irq, 0);
    chk("rst_mid_busy", busy, 0);
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      chk("rst_quiet_tx", tx, 1);
    end
    chk("rst_quiet_busy", busy, 0);
    irq_en = 1'b0;
    clk_div = 32'd1;
    send_write(8'h0F);
    chk_frame(8'h0F, 1, 0);
    irq_en = 1'b1;
    @(negedge clk);
    chk("irq_no_retro", irq, 0);
    send_write(8'hF0);
    chk_frame(8'hF0, 1, 1);
    irq_en = 1'b0;
    @(negedge clk);
    chk("irq_en_clr", irq, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_transmit.md
Name: uart_transmit

Overview:
- UART transmitter (8N1, LSB first), companion to the UART receiver in the same peripheral.
- Takes bytes from the bus-side register interface through a one-byte holding register and serialises them on `tx`.
- The bit period is programmed by `clk_div`, with the same meaning as on the receive side: `clk_div` clock cycles per bit.
- Raises a level interrupt when the line goes idle with nothing left to send.

Parameters:
- none (frame format fixed at 1 start, 8 data, 1 stop, no parity)

Ports:
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst`  input  1  synchronous, active-low reset; sampled on the `clk` rising edge.
- `clk_div`  input  32  clock cycles per bit; 0 is treated as 1.
- `tx_data`  input  8  byte to send; sampled when `write` is accepted.
- `write`  input  1  one-cycle request to load `tx_data`.
- `irq_en`  input  1  enables `irq`.
- `clr_ovr`  input  1  clears `overrun`.
- `tx`  output  1  serial line; idle high.
- `full`  output  1  holding register occupied.
- `busy`  output  1  frame in progress or holding register occupied.
- `overrun`  output  1  sticky: a write was dropped because `full` was 1.
- `irq`  output  1  transmitter drained (level).

Behaviour:
- **Reset** (`rst` == 0 at a clock edge):
  - state = IDLE; `tx` = 1; `full` = 0; `busy` = 0; `overrun` = 0; `irq` = 0.
  - Bit counter, cycle counter and shift register are cleared.
  - Reset mid-frame aborts the frame immediately; `tx` returns high on that edge and the holding byte is discarded.
- **Write acceptance:**
  - `write` is accepted iff `full` == 0 in that cycle.
  - On the next edge the holding register takes `tx_data` and `full` = 1.
  - `write` while `full` == 1 is dropped: data is unchanged and `overrun` is set on the next edge.
  - If `clr_ovr` and a dropped write occur in the same cycle, set wins.
- **Registers and derived outputs:**
  - Latched bit period `per` = max(`clk_div`, 1), captured at frame load; changing `clk_div` mid-frame does not affect the current frame.
  - `busy` = (state != IDLE) | `full`, combinational from registers.
- **IDLE:**
  - `tx` = 1.
  - If `full` == 1: on the next edge, shift register takes the holding byte, `full` = 0, cycle count = 0, state = START, `tx` = 0.
  - Latency: `write` accepted in cycle k → `full` rises at edge k+1 → `tx` falls at edge k+2.
- **START:**
  - `tx` = 0 for `per` cycles.
  - Then state = DATA, bit index = 0, `tx` = shift[0].
- **DATA:**
  - Each bit is held for `per` cycles, LSB first.
  - After bit index 7 completes: state = STOP, `tx` = 1.
  - Bit index is 3 bits and wraps only after the transition to STOP.
- **STOP:**
  - `tx` = 1 for `per` cycles.
  - At completion, if `full` == 1: load the next byte directly to START (`tx` = 0 on the same edge, zero idle gap).
  - Otherwise state = IDLE.
  - The holding register can be refilled at any time during a frame, including on the same edge it is emptied (the write is accepted because `full` was 0 in that cycle).
- **Frame length:** 10 × `per` cycles exactly.
- **Cycle counter:** 32 bits; counts 0 … `per`−1, then reloads 0. `per` = 1 gives one-cycle bits.
- **irq:**
  - Set (if `irq_en` == 1) on the edge where STOP completes with `full` == 0.
  - Held high until a write is accepted, `irq_en` = 0, or reset; clearing takes effect on the next edge.
  - Never asserted while `irq_en` == 0; enabling `irq_en` later while idle does not retro-assert.
- **Default / illegal state:** recover to IDLE with reset values.

Test Plan:
- **Single byte:** reset, `clk_div` = 4, write 0xA5 → from edge k+2, `tx` = 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 cycles; `busy` falls after 40 cycles; `irq` = 1 with `irq_en` = 1.
- **Back-to-back:** `clk_div` = 3; write 0x00, then 0xFF while the first frame is in START → 60 contiguous cycles with no idle high between the stop bit and the next start bit; `full` 1→0 at the second load.
- **Overrun:** hold `full` = 1 with a frame in progress; write 0x12 → byte dropped, `overrun` = 1, queued byte sent unchanged. Pulse `clr_ovr` → `overrun` = 0.
- **Divider edge cases:** `clk_div` = 0 and `clk_div` = 1 → 10-cycle frame. Change `clk_div` 8→2 mid-frame → current frame stays at 80 cycles; next frame is 20 cycles.
- **Reset mid-frame:** assert `rst` = 0 for one cycle during DATA bit 3 → `tx` = 1, `full` = 0, `irq` = 0 next edge; no residual bits appear after reset is released.
- **irq handshake:** `irq_en` = 0 during the frame → `irq` stays 0. Repeat with `irq_en` = 1 → `irq` = 1 after the stop bit; a write clears it on the next edge.
